forward_unit: RTL and testbench

FORWARD_UNIT -- requirements
Module: forward_unit

---
 rtl/forward_unit.sv | 137 +++++++++++++
 tb/tb_forward_unit.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/forward_unit.sv
// rtl/forward_unit.sv - EX-stage Op2 forwarding select and load-use stall detection
// Tracks EX/MEM/WB destination tags and overrides the ALU B-mux when Op2 is still in flight.
module forward_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        id_valid,
    input  logic [3:0]  id_rd,
    input  logic        id_regwrite,
    input  logic        id_wr_r15,
    input  logic        id_memread,
    input  logic [3:0]  id_rs2,
    input  logic        id_uses_op2,
    input  logic [3:0]  ex_rs2,
    input  logic        flush,
    output logic        hazard,
    output logic [2:0]  forward_sel,
    output logic        stall,
    output logic [15:0] stall_count
);

    localparam logic [2:0] SEL_NONE    = 3'b000;
    localparam logic [2:0] SEL_MEM_LO  = 3'b001;
    localparam logic [2:0] SEL_MEM_HI  = 3'b010;
    localparam logic [2:0] SEL_WB_LO   = 3'b011;
    localparam logic [2:0] SEL_WB_HI   = 3'b100;

    logic        r_ex_valid;
    logic [3:0]  r_ex_rd;
    logic        r_ex_regwrite;
    logic        r_ex_wr_r15;
    logic        r_ex_memread;

    logic        r_mem_valid;
    logic [3:0]  r_mem_rd;
    logic        r_mem_regwrite;
    logic        r_mem_wr_r15;
    logic        r_mem_memread;

    // WB never blocks forwarding, so its memread flag is not kept.
    logic        r_wb_valid;
    logic [3:0]  r_wb_rd;
    logic        r_wb_regwrite;
    logic        r_wb_wr_r15;

    logic [15:0] r_stall_count;

    logic        w_rs2_nz;
    logic        w_rs2_r15;
    logic        w_mem_low;
    logic        w_mem_high;
    logic        w_wb_low;
    logic        w_wb_high;
    logic        w_stall;
    logic        w_ex_bubble;

    assign w_rs2_nz   = (ex_rs2 != 4'd0);
    assign w_rs2_r15  = (ex_rs2 == 4'd15);

    // A load in MEM has no data in Btb yet; only WB may supply it.
    assign w_mem_low  = r_mem_valid & r_mem_regwrite & ~r_mem_memread & (r_mem_rd == ex_rs2) & w_rs2_nz;
    assign w_mem_high = r_mem_valid & r_mem_wr_r15 & ~r_mem_memread & w_rs2_r15;
    assign w_wb_low   = r_wb_valid & r_wb_regwrite & (r_wb_rd == ex_rs2) & w_rs2_nz;
    assign w_wb_high  = r_wb_valid & r_wb_wr_r15 & w_rs2_r15;

    always_comb begin
        forward_sel = SEL_NONE;
        if (w_mem_high) begin
            forward_sel = SEL_MEM_HI;
        end else if (w_mem_low) begin
            forward_sel = SEL_MEM_LO;
        end else if (w_wb_high) begin
            forward_sel = SEL_WB_HI;
        end else if (w_wb_low) begin
            forward_sel = SEL_WB_LO;
        end
    end

    assign hazard = (forward_sel != SEL_NONE);

    assign w_stall = id_valid & id_uses_op2 & r_ex_valid & r_ex_memread & r_ex_regwrite
                   & (r_ex_rd == id_rs2) & (id_rs2 != 4'd0) & ~flush;
    assign w_ex_bubble = w_stall | flush | ~id_valid;

    assign stall       = w_stall;
    assign stall_count = r_stall_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ex_valid     <= 1'b0;
            r_ex_rd        <= 4'd0;
            r_ex_regwrite  <= 1'b0;
            r_ex_wr_r15    <= 1'b0;
            r_ex_memread   <= 1'b0;
            r_mem_valid    <= 1'b0;
            r_mem_rd       <= 4'd0;
            r_mem_regwrite <= 1'b0;
            r_mem_wr_r15   <= 1'b0;
            r_mem_memread  <= 1'b0;
            r_wb_valid     <= 1'b0;
            r_wb_rd        <= 4'd0;
            r_wb_regwrite  <= 1'b0;
            r_wb_wr_r15    <= 1'b0;
        end else begin
            r_wb_valid     <= r_mem_valid;
            r_wb_rd        <= r_mem_rd;
            r_wb_regwrite  <= r_mem_regwrite;
            r_wb_wr_r15    <= r_mem_wr_r15;
            r_mem_valid    <= r_ex_valid;
            r_mem_rd       <= r_ex_rd;
            r_mem_regwrite <= r_ex_regwrite;
            r_mem_wr_r15   <= r_ex_wr_r15;
            r_mem_memread  <= r_ex_memread;
            if (w_ex_bubble) begin
                r_ex_valid    <= 1'b0;
                r_ex_rd       <= 4'd0;
                r_ex_regwrite <= 1'b0;
                r_ex_wr_r15   <= 1'b0;
                r_ex_memread  <= 1'b0;
            end else begin
                r_ex_valid    <= 1'b1;
                r_ex_rd       <= id_rd;
                r_ex_regwrite <= id_regwrite;
                r_ex_wr_r15   <= id_wr_r15;
                r_ex_memread  <= id_memread;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_count <= 16'd0;
        end else if (w_stall && (r_stall_count != 16'hFFFF)) begin
            r_stall_count <= r_stall_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_forward_unit.sv
// tb/tb_forward_unit.sv - scoreboard bench for forward_unit
module tb_forward_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid;
    logic [3:0]  id_rd;
    logic        id_regwrite;
    logic        id_wr_r15;
    logic        id_memread;
    logic [3:0]  id_rs2;
    logic        id_uses_op2;
    logic [3:0]  ex_rs2;
    logic        flush;
    logic        hazard;
    logic [2:0]  forward_sel;
    logic        stall;
    logic [15:0] stall_count;

    always #5 clk = ~clk;

    forward_unit dut (
        .clk         (clk),
        .rst         (rst),
        .id_valid    (id_valid),
        .id_rd       (id_rd),
        .id_regwrite (id_regwrite),
        .id_wr_r15   (id_wr_r15),
        .id_memread  (id_memread),
        .id_rs2      (id_rs2),
        .id_uses_op2 (id_uses_op2),
        .ex_rs2      (ex_rs2),
        .flush       (flush),
        .hazard      (hazard),
        .forward_sel (forward_sel),
        .stall       (stall),
        .stall_count (stall_count)
    );

    typedef struct packed {
        logic       v;
        logic [3:0] rd;
        logic       rw;
        logic       r15;
        logic       mr;
    } tag_t;

    typedef struct packed {
        logic [2:0]  fsel;
        logic        hz;
        logic        st;
        logic [15:0] cnt;
    } want_t;

    int    n_tests = 0;
    int    n_fail  = 0;
    tag_t  m_ex;
    tag_t  m_mem;
    tag_t  m_wb;
    logic [15:0] m_cnt;
    want_t sb[$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    function automatic logic [2:0] model_fsel(input logic [3:0] rs2);
        if (rs2 == 4'd0) return 3'd0;
        if (m_mem.v && !m_mem.mr && m_mem.r15 && rs2 == 4'd15) return 3'd2;
        if (m_mem.v && !m_mem.mr && m_mem.rw && m_mem.rd == rs2) return 3'd1;
        if (m_wb.v && m_wb.r15 && rs2 == 4'd15) return 3'd4;
        if (m_wb.v && m_wb.rw && m_wb.rd == rs2) return 3'd3;
        return 3'd0;
    endfunction

    task automatic model_clear();
        m_ex  = '0;
        m_mem = '0;
        m_wb  = '0;
        m_cnt = 16'd0;
    endtask

    // One cycle: drive decode/EX inputs, predict, compare at negedge, advance model at posedge.
    task automatic step(input logic v, input logic [3:0] rd, input logic rw, input logic r15,
                        input logic mr, input logic [3:0] rs2, input logic uses,
                        input logic [3:0] xrs2, input logic fl, input int wf, input int ws);
        want_t w;
        logic  st;
        id_valid = v; id_rd = rd; id_regwrite = rw; id_wr_r15 = r15; id_memread = mr;
        id_rs2 = rs2; id_uses_op2 = uses; ex_rs2 = xrs2; flush = fl;
        st = v && uses && m_ex.v && m_ex.mr && m_ex.rw && (m_ex.rd == rs2) && (rs2 != 4'd0) && !fl;
        w.fsel = model_fsel(xrs2);
        w.hz   = (w.fsel != 3'd0);
        w.st   = st;
        w.cnt  = m_cnt;
        sb.push_back(w);
        @(negedge clk);
        w = sb.pop_front();
        check_eq("forward_sel", 32'(forward_sel), 32'(w.fsel));
        check_eq("hazard", 32'(hazard), 32'(w.hz));
        check_eq("stall", 32'(stall), 32'(w.st));
        check_eq("stall_count", 32'(stall_count), 32'(w.cnt));
        if (wf >= 0) check_eq("directed_fsel", 32'(forward_sel), 32'(wf));
        if (ws >= 0) check_eq("directed_stall", 32'(stall), 32'(ws));
        @(posedge clk);
        if (st && m_cnt != 16'hFFFF) m_cnt++;
        m_wb  = m_mem;
        m_mem = m_ex;
        m_ex  = (st || fl || !v) ? tag_t'(0) : tag_t'({1'b1, rd, rw, r15, mr});
        #1;
    endtask

    task automatic op(input logic [3:0] rd, input logic rw, input logic r15, input logic mr,
                      input logic [3:0] rs2, input logic uses, input logic [3:0] xrs2,
                      input int wf, input int ws);
        step(1'b1, rd, rw, r15, mr, rs2, uses, xrs2, 1'b0, wf, ws);
    endtask

    task automatic nop(input logic [3:0] xrs2, input int wf);
        step(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, xrs2, 1'b0, wf, -1);
    endtask

    task automatic drain();
        for (int i = 0; i < 3; i++) nop(4'd0, 0);
    endtask

    initial begin
        rst = 1'b1;
        id_valid = 1'b0; id_rd = 4'd0; id_regwrite = 1'b0; id_wr_r15 = 1'b0; id_memread = 1'b0;
        id_rs2 = 4'd0; id_uses_op2 = 1'b0; ex_rs2 = 4'd0; flush = 1'b0;
        model_clear();
        #2;
        check_eq("reset_fsel", 32'(forward_sel), 32'd0);
        check_eq("reset_hazard", 32'(hazard), 32'd0);
        check_eq("reset_stall", 32'(stall), 32'd0);
        check_eq("reset_count", 32'(stall_count), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // ADD r3 then a reader of r3: MEM forward, then WB forward
        op(4'd3, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0, -1, 0);
        op(4'd7, 1'b0, 1'b0, 1'b0, 4'd3, 1'b1, 4'd0, 0, 0);
        op(4'd8, 1'b0, 1'b0, 1'b0, 4'd3, 1'b1, 4'd3, 1, 0);
        nop(4'd3, 3);
        drain();

        // MUL writing R15: adjacent -> 010, one NOP gap -> 100
        op(4'd4, 1'b1, 1'b1, 1'b0, 4'd0, 1'b0, 4'd0, -1, 0);
        op(4'd7, 1'b0, 1'b0, 1'b0, 4'd15, 1'b1, 4'd0, 0, 0);
        nop(4'd15, 2);
        drain();
        op(4'd4, 1'b1, 1'b1, 1'b0, 4'd0, 1'b0, 4'd0, -1, 0);
        nop(4'd0, 0);
        op(4'd7, 1'b0, 1'b0, 1'b0, 4'd15, 1'b1, 4'd0, 0, 0);
        nop(4'd15, 4);
        drain();

        // Load-use: one stall cycle, then WB forward to the dependent op
        op(4'd5, 1'b1, 1'b0, 1'b1, 4'd0, 1'b0, 4'd0, -1, 0);
        op(4'd7, 1'b0, 1'b0, 1'b0, 4'd5, 1'b1, 4'd0, 0, 1);
        op(4'd7, 1'b0, 1'b0, 1'b0, 4'd5, 1'b1, 4'd0, 0, 0);
        nop(4'd5, 3);
        drain();

        // MEM beats WB; R0 never forwards; a load in MEM does not forward
        op(4'd6, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0, -1, 0);
        op(4'd6, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0, -1, 0);
        nop(4'd6, 1);
        drain();
        op(4'd0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0, -1, 0);
        op(4'd0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0, -1, 0);
        nop(4'd0, 0);
        drain();
        op(4'd9, 1'b1, 1'b0, 1'b1, 4'd0, 1'b0, 4'd0, -1, 0);
        nop(4'd0, 0);
        nop(4'd9, 0);
        nop(4'd9, 3);
        drain();

        // Flush beats load-use stall
        op(4'd5, 1'b1, 1'b0, 1'b1, 4'd0, 1'b0, 4'd0, -1, 0);
        step(1'b1, 4'd7, 1'b0, 1'b0, 1'b0, 4'd5, 1'b1, 4'd0, 1'b1, 0, 0);
        drain();

        // Saturation at FFFF
        force dut.r_stall_count = 16'hFFFE;
        #1;
        release dut.r_stall_count;
        m_cnt = 16'hFFFE;
        for (int k = 0; k < 2; k++) begin
            op(4'd5, 1'b1, 1'b0, 1'b1, 4'd0, 1'b0, 4'd0, -1, 0);
            op(4'd7, 1'b0, 1'b0, 1'b0, 4'd5, 1'b1, 4'd0, -1, 1);
            nop(4'd0, -1);
        end
        check_eq("sat_count", 32'(stall_count), 32'h0000FFFF);
        drain();

        // Async reset during a stall with a valid MEM tag
        op(4'd1, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0, -1, 0);
        op(4'd5, 1'b1, 1'b0, 1'b1, 4'd0, 1'b0, 4'd0, -1, 0);
        id_valid = 1'b1; id_rd = 4'd7; id_regwrite = 1'b0; id_wr_r15 = 1'b0; id_memread = 1'b0;
        id_rs2 = 4'd5; id_uses_op2 = 1'b1; ex_rs2 = 4'd1; flush = 1'b0;
        #1;
        check_eq("pre_rst_stall", 32'(stall), 32'd1);
        check_eq("pre_rst_fsel", 32'(forward_sel), 32'd1);
        rst = 1'b1;
        #1;
        check_eq("rst_stall", 32'(stall), 32'd0);
        check_eq("rst_hazard", 32'(hazard), 32'd0);
        check_eq("rst_fsel", 32'(forward_sel), 32'd0);
        check_eq("rst_count", 32'(stall_count), 32'd0);
        model_clear();
        @(posedge clk); #1;
        rst = 1'b0;
        nop(4'd1, 0);
        nop(4'd5, 0);

        // Random traffic against the model
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 9) != 0), 4'($urandom_range(0, 15)), 1'($urandom),
                 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 2) == 0),
                 4'($urandom_range(0, 15)), 1'($urandom), 4'($urandom_range(0, 15)),
                 1'($urandom_range(0, 11) == 0), -1, -1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
